// File: rtl/nextasic_serial_receiver.sv
// nextasic_serial_receiver
// Receiving end of the single-wire NeXT ASIC serial link. Each packet is a
// start bit (1) followed by 40 payload bits, MSB first, one bit per clock.
// After every packet the line must stay low for MIN_GAP cycles before the
// next start bit. Control payloads (audio sample request and audio underrun)
// become one-cycle strobes; all other payloads go to a one-deep valid/ready
// holding register for the downstream decoder.

module nextasic_serial_receiver #(
    parameter int unsigned MIN_GAP   = 3,
    parameter bit          PASS_CTRL = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        audio_req,
    output logic        audio_underrun,
    output logic        data_loss,
    output logic        framing_error
);

    // The gap counter holds values up to MIN_GAP. A zero gap would give a
    // zero-width counter, so keep at least one bit.
    localparam int GAP_W = (MIN_GAP == 0) ? 1 : $clog2(MIN_GAP + 1);

    // Gap counter value on which the final mandatory idle bit is seen.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((MIN_GAP == 0) ? 0 : (MIN_GAP - 1));

    // Index of the last payload bit within a packet.
    localparam logic [5:0] LAST_BIT = 6'd39;

    // Control payloads that are turned into strobes.
    localparam logic [39:0] AUDIO_REQ_WORD      = 40'h07_0000_0000;
    localparam logic [39:0] AUDIO_UNDERRUN_WORD = 40'h0F_0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state;
    logic [5:0]       bit_cnt;
    logic [GAP_W-1:0] gap_cnt;

    // Only 39 payload bits ever need storing: the 40th arrives on sin at the
    // completing edge and is combined with the stored bits on the fly.
    logic [38:0]      shift_reg;

    logic [39:0]      next_shift;
    logic             is_req;
    logic             is_underrun;
    logic             is_data;
    logic             slot_free;

    // Payload as it will look once the current sin bit is shifted in, plus
    // its classification. Only meaningful at the final payload bit.
    always_comb begin
        next_shift  = {shift_reg, sin};
        is_req      = (next_shift == AUDIO_REQ_WORD);
        is_underrun = (next_shift == AUDIO_UNDERRUN_WORD);
        is_data     = PASS_CTRL || !(is_req || is_underrun);
        slot_free   = !out_valid || out_ready;
    end

    // Framing FSM, payload shift register, holding register and strobes.
    // Strobes default low every cycle so they are never held; a handshake
    // empties the holding register unless a new payload lands on that edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
            shift_reg      <= '0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            audio_req      <= 1'b0;
            audio_underrun <= 1'b0;
            data_loss      <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            audio_req      <= 1'b0;
            audio_underrun <= 1'b0;
            data_loss      <= 1'b0;
            framing_error  <= 1'b0;

            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (sin) begin
                        state   <= SHIFT;
                        bit_cnt <= '0;
                    end
                end

                SHIFT: begin
                    shift_reg <= next_shift[38:0];
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt        <= '0;
                        gap_cnt        <= '0;
                        audio_req      <= is_req;
                        audio_underrun <= is_underrun;
                        if (is_data) begin
                            if (slot_free) begin
                                out_data  <= next_shift;
                                out_valid <= 1'b1;
                            end else begin
                                data_loss <= 1'b1;
                            end
                        end
                        if (MIN_GAP == 0) begin
                            state <= IDLE;
                        end else begin
                            state <= GAP;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                    end
                end

                GAP: begin
                    if (sin) begin
                        // A start bit inside the gap is flagged but still
                        // taken as the start of a packet so the link resyncs.
                        framing_error <= 1'b1;
                        state         <= SHIFT;
                        bit_cnt       <= '0;
                    end else if (gap_cnt == GAP_LAST) begin
                        state   <= IDLE;
                        gap_cnt <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nextasic_serial_receiver.sv
// tb_nextasic_serial_receiver
// Directed bench for the serial receiver. Expected data payloads are queued
// as packets are driven and popped by a monitor on every handshake; pulse
// timing is checked directly one cycle after the last payload bit.

module tb_nextasic_serial_receiver;

    logic        clk;
    logic        rst_n;
    logic        sin;
    logic        out_ready;

    logic [39:0] out_data;
    logic        out_valid;
    logic        audio_req;
    logic        audio_underrun;
    logic        data_loss;
    logic        framing_error;

    logic [39:0] pc_out_data;
    logic        pc_out_valid;
    logic        pc_audio_req;
    logic        pc_audio_underrun;
    logic        pc_data_loss;
    logic        pc_framing_error;

    int          tests_run    = 0;
    int          tests_failed = 0;
    int          req_cnt      = 0;
    int          underrun_cnt = 0;
    int          loss_cnt     = 0;
    int          frame_cnt    = 0;
    logic [39:0] exp_q[$];
    logic [39:0] pkt;

    nextasic_serial_receiver #(.MIN_GAP(3), .PASS_CTRL(1'b0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sin            (sin),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .audio_req      (audio_req),
        .audio_underrun (audio_underrun),
        .data_loss      (data_loss),
        .framing_error  (framing_error)
    );

    // Second instance forwards control payloads too; shares all inputs.
    nextasic_serial_receiver #(.MIN_GAP(3), .PASS_CTRL(1'b1)) dut_pc (
        .clk            (clk),
        .rst_n          (rst_n),
        .sin            (sin),
        .out_data       (pc_out_data),
        .out_valid      (pc_out_valid),
        .out_ready      (out_ready),
        .audio_req      (pc_audio_req),
        .audio_underrun (pc_audio_underrun),
        .data_loss      (pc_data_loss),
        .framing_error  (pc_framing_error)
    );

    // Free-running clock, 10 time units per serial bit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Drive one serial bit; it is sampled at the following rising edge.
    task automatic applyStimulus(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_bits(input logic [39:0] p, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            applyStimulus(p[i]);
        end
    endtask

    task automatic send_packet(input logic [39:0] p);
        applyStimulus(1'b1);
        send_bits(p, 39, 0);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0);
    endtask

    // Monitor: counts strobes, checks strobe exclusivity and scores every
    // handshake of the main instance against the expected-payload queue.
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            req_cnt      += int'(audio_req);
            underrun_cnt += int'(audio_underrun);
            loss_cnt     += int'(data_loss);
            frame_cnt    += int'(framing_error);
            if (audio_req || audio_underrun || data_loss) begin
                checkOutput("pulse_exclusive",
                            40'($countones({audio_req, audio_underrun, data_loss})), 40'd1);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $error("[TB] FAIL unexpected_data observed=%h expected=none", out_data);
                end else begin
                    checkOutput("scoreboard", out_data, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        sin       = 1'b0;
        out_ready = 1'b1;
        rst_n     = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        #2;
        checkOutput("reset_data", out_data, 40'd0);
        checkOutput("reset_valid", 40'(out_valid), 40'd0);
        checkOutput("reset_pulses", 40'({audio_req, audio_underrun, data_loss, framing_error}), 40'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Plain data packet with consumer ready
        pkt = 40'hD9_9999_9991;
        exp_q.push_back(pkt);
        send_packet(pkt);
        applyStimulus(1'b0);
        #2;
        checkOutput("t1_valid", 40'(out_valid), 40'd1);
        checkOutput("t1_data", out_data, pkt);
        checkOutput("t1_pulses", 40'({audio_req, audio_underrun, data_loss, framing_error}), 40'd0);
        idle(4);
        checkOutput("t1_consumed", 40'(out_valid), 40'd0);

        // Audio request, 4 idle bits, then data
        send_packet(40'h07_0000_0000);
        applyStimulus(1'b0);
        #2;
        checkOutput("req_pulse", 40'(audio_req), 40'd1);
        checkOutput("req_no_data", 40'(out_valid), 40'd0);
        idle(3);
        pkt = 40'hD9_9999_9993;
        exp_q.push_back(pkt);
        send_packet(pkt);
        applyStimulus(1'b0);
        #2;
        checkOutput("req_follow_data", out_data, pkt);
        checkOutput("req_pulse_gone", 40'(audio_req), 40'd0);
        idle(4);
        checkOutput("req_no_frame_err", 40'(frame_cnt), 40'd0);

        // Audio underrun on both instances
        send_packet(40'h0F_0000_0000);
        applyStimulus(1'b0);
        #2;
        checkOutput("underrun_pulse", 40'(audio_underrun), 40'd1);
        checkOutput("underrun_no_data", 40'(out_valid), 40'd0);
        checkOutput("pc_underrun_pulse", 40'(pc_audio_underrun), 40'd1);
        checkOutput("pc_underrun_valid", 40'(pc_out_valid), 40'd1);
        checkOutput("pc_underrun_data", pc_out_data, 40'h0F_0000_0000);
        idle(4);

        // Back-to-back request and data with exactly the minimum gap
        send_packet(40'h07_0000_0000);
        idle(3);
        pkt = 40'hD9_9999_9995;
        exp_q.push_back(pkt);
        send_packet(pkt);
        applyStimulus(1'b0);
        #2;
        checkOutput("b2b_data", out_data, pkt);
        checkOutput("b2b_frame_cnt", 40'(frame_cnt), 40'd0);
        checkOutput("b2b_req_cnt", 40'(req_cnt), 40'd2);
        idle(4);

        // All-zero payload is ordinary data
        exp_q.push_back(40'd0);
        send_packet(40'd0);
        applyStimulus(1'b0);
        #2;
        checkOutput("zero_valid", 40'(out_valid), 40'd1);
        checkOutput("zero_data", out_data, 40'd0);
        idle(4);

        // Holding register full: second payload dropped
        @(negedge clk);
        out_ready = 1'b0;
        pkt = 40'hD9_9999_9991;
        exp_q.push_back(pkt);
        send_packet(pkt);
        idle(4);
        send_packet(40'hD9_9999_9997);
        applyStimulus(1'b0);
        #2;
        checkOutput("loss_pulse", 40'(data_loss), 40'd1);
        checkOutput("loss_data_kept", out_data, pkt);
        checkOutput("loss_valid", 40'(out_valid), 40'd1);
        applyStimulus(1'b0);
        #2;
        checkOutput("loss_pulse_gone", 40'(data_loss), 40'd0);
        idle(2);
        @(negedge clk);
        out_ready = 1'b1;
        applyStimulus(1'b0);
        #2;
        checkOutput("loss_drained", 40'(out_valid), 40'd0);
        idle(2);

        // Consumer ready exactly at the second completion edge
        @(negedge clk);
        out_ready = 1'b0;
        exp_q.push_back(40'hD9_9999_9991);
        send_packet(40'hD9_9999_9991);
        idle(4);
        pkt = 40'hD9_9999_9997;
        exp_q.push_back(pkt);
        applyStimulus(1'b1);
        send_bits(pkt, 39, 1);
        @(negedge clk);
        sin       = pkt[0];
        out_ready = 1'b1;
        applyStimulus(1'b0);
        #2;
        checkOutput("swap_valid", 40'(out_valid), 40'd1);
        checkOutput("swap_data", out_data, pkt);
        checkOutput("swap_no_loss", 40'(data_loss), 40'd0);
        idle(4);
        checkOutput("loss_cnt", 40'(loss_cnt), 40'd1);

        // Start bit on the second gap cycle
        pkt = 40'h12_3456_7890;
        exp_q.push_back(pkt);
        send_packet(pkt);
        applyStimulus(1'b0);
        applyStimulus(1'b1);
        pkt = 40'hA5_A5A5_A5A5;
        exp_q.push_back(pkt);
        send_bits(pkt, 39, 39);
        #2;
        checkOutput("frame_pulse", 40'(framing_error), 40'd1);
        send_bits(pkt, 38, 38);
        #2;
        checkOutput("frame_pulse_gone", 40'(framing_error), 40'd0);
        send_bits(pkt, 37, 0);
        applyStimulus(1'b0);
        #2;
        checkOutput("frame_resync_data", out_data, pkt);
        checkOutput("frame_resync_valid", 40'(out_valid), 40'd1);
        idle(4);
        checkOutput("frame_cnt", 40'(frame_cnt), 40'd1);

        // Reset in the middle of a packet
        pkt = 40'hCA_FEBA_BE12;
        applyStimulus(1'b1);
        send_bits(pkt, 39, 20);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sin   = 1'b0;
        #1;
        checkOutput("midrst_data", out_data, 40'd0);
        checkOutput("midrst_valid", 40'(out_valid), 40'd0);
        checkOutput("midrst_pulses", 40'({audio_req, audio_underrun, data_loss, framing_error}), 40'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        pkt = 40'h00_0000_0001;
        exp_q.push_back(pkt);
        send_packet(pkt);
        applyStimulus(1'b0);
        #2;
        checkOutput("postrst_data", out_data, pkt);
        checkOutput("postrst_valid", 40'(out_valid), 40'd1);
        idle(4);

        // Totals
        checkOutput("queue_empty", 40'(exp_q.size()), 40'd0);
        checkOutput("req_total", 40'(req_cnt), 40'd2);
        checkOutput("underrun_total", 40'(underrun_cnt), 40'd1);
        checkOutput("loss_total", 40'(loss_cnt), 40'd1);
        checkOutput("frame_total", 40'(frame_cnt), 40'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
